// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm -- direct-mapped, read-only instruction cache.
//
// Sits between the fetch stage (pc/instr) and external instruction memory.
// A hit returns the instruction combinationally in the same cycle. A miss
// raises stall and a two-state FSM refills the line one word at a time over
// a req/ack handshake. Tags, valid bits and data are all held in flops.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   pc         fetch byte address (pc[1:0] ignored)
//   instr      fetched instruction, NOP (addi x0,x0,0) when not hitting
//   stall      high while the current pc does not hit
//   flush      one-cycle pulse invalidating every line (fence.i)
//   mem_req    refill word request, registered, held until mem_ack
//   mem_addr   refill word byte address, registered, word-aligned
//   mem_ack    requested word is present on mem_rdata this cycle
//   mem_rdata  refill data
//
// Optional feature (macro ICACHE_STATS_EN):
//   hit_count  IDLE cycles that hit (wraps modulo 2^32)
//   miss_count IDLE->REFILL transitions (wraps modulo 2^32)
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WO_B  = $clog2(WORDS);
    localparam int IX_B  = $clog2(LINES);
    localparam int TAG_W = 32 - WO_B - IX_B - 2;

    localparam logic [31:0]     NOP       = 32'h0000_0013;
    localparam logic [WO_B-1:0] LAST_WORD = WO_B'(WORDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t              state;
    logic [LINES-1:0]    validBits;
    logic [TAG_W-1:0]    tagMem  [LINES];
    logic [31:0]         dataMem [LINES][WORDS];

    logic [TAG_W-1:0]    refillTag;
    logic [IX_B-1:0]     refillIdx;
    logic [WO_B-1:0]     wordCnt;
    logic                kill;

    logic [WO_B-1:0]     pcOff;
    logic [IX_B-1:0]     pcIdx;
    logic [TAG_W-1:0]    pcTag;
    logic                hit;
    logic                wordAck;
    logic                lastAck;
    logic [WO_B-1:0]     nextCnt;
    logic                unusedPcLsb;

    assign pcOff = pc[2 +: WO_B];
    assign pcIdx = pc[2 + WO_B +: IX_B];
    assign pcTag = pc[31 -: TAG_W];

    // Byte-lane bits never select anything in a word-granular cache.
    assign unusedPcLsb = ^pc[1:0];

    // Lookup is suppressed during REFILL so the pipeline stays stalled until
    // the FSM is back in IDLE, even if pc wanders onto a valid line.
    assign hit   = validBits[pcIdx] && (tagMem[pcIdx] == pcTag) && (state == IDLE);
    assign instr = hit ? dataMem[pcIdx][pcOff] : NOP;
    assign stall = ~hit;

    // mem_req is only ever high in REFILL, so an ack outside a request is ignored.
    assign wordAck = (state == REFILL) && mem_req && mem_ack;
    assign lastAck = wordAck && (wordCnt == LAST_WORD);
    assign nextCnt = wordCnt + 1'b1;

    // ---- control: FSM, valid bits, refill request ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            validBits <= '0;
            wordCnt   <= '0;
            kill      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            refillTag <= '0;
            refillIdx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        validBits <= '0;
                    end else if (!hit) begin
                        refillTag <= pcTag;
                        refillIdx <= pcIdx;
                        wordCnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {pcTag, pcIdx, {WO_B{1'b0}}, 2'b00};
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    // A flush mid-refill cannot stop the line transfer, so it is
                    // remembered in kill and the finished line is left invalid.
                    if (flush) begin
                        validBits <= '0;
                        kill      <= 1'b1;
                    end
                    if (wordAck) begin
                        wordCnt <= nextCnt;
                        if (lastAck) begin
                            validBits[refillIdx] <= ~(kill | flush);
                            kill    <= 1'b0;
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            mem_addr <= {refillTag, refillIdx, nextCnt, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- data: line storage, written only by refill acks ----
    always_ff @(posedge clk) begin
        if (wordAck) begin
            dataMem[refillIdx][wordCnt] <= mem_rdata;
            if (lastAck) begin
                tagMem[refillIdx] <= refillTag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // ---- statistics ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && !flush && !hit) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int testsRun;
    int testsFailed;

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory contents: lines at 0x000 hold 0xA0..0xA3, lines at 0x100 hold 0xB0..0xB3.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a[8] ? 32'h0000_00B0 : 32'h0000_00A0) + {30'd0, a[3:2]};
    endfunction

    // One clock: the memory answers any request visible now with a single-cycle
    // ack, then outputs are sampled 1ns after the rising edge.
    task automatic cycle();
        mem_ack   = mem_req;
        mem_rdata = memData(mem_addr);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    // Full miss + refill of the line at base, with pc == base held throughout.
    task automatic doRefill(input string tag, input logic [31:0] base);
        checkVal({tag, ".missStall"}, 32'(stall), 32'd1);
        checkVal({tag, ".missInstr"}, instr, NOP);
        cycle();
        for (int w = 0; w < 4; w++) begin
            checkVal({tag, ".req"}, 32'(mem_req), 32'd1);
            checkVal({tag, ".addr"}, mem_addr, base + 32'(4 * w));
            checkVal({tag, ".busyStall"}, 32'(stall), 32'd1);
            cycle();
        end
        checkVal({tag, ".reqDrop"}, 32'(mem_req), 32'd0);
        checkVal({tag, ".hitStall"}, 32'(stall), 32'd0);
        checkVal({tag, ".hitInstr"}, instr, memData(base));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkVal("rst.req", 32'(mem_req), 32'd0);
        checkVal("rst.addr", mem_addr, 32'h0);
        checkVal("rst.stall", 32'(stall), 32'd1);
        checkVal("rst.instr", instr, NOP);

        // Cold miss on 0x0
        reset = 1'b1;
        #1;
        doRefill("cold", 32'h0);

        // Hits on the rest of line 0, starting with the 0x0 hit cycle
        cycle();
        for (int w = 1; w < 4; w++) begin
            pc = 32'(4 * w);
            #1;
            checkVal("hit.stall", 32'(stall), 32'd0);
            checkVal("hit.instr", instr, 32'h0000_00A0 + 32'(w));
            checkVal("hit.req", 32'(mem_req), 32'd0);
            cycle();
        end
`ifdef ICACHE_STATS_EN
        checkVal("stats.miss", miss_count, 32'd1);
        checkVal("stats.hit", hit_count, 32'd4);
`endif

        // Conflict: 0x100 evicts line 0, then 0x0 misses again
        pc = 32'h100;
        #1;
        doRefill("conf100", 32'h100);
        pc = 32'h0;
        #1;
        doRefill("conf000", 32'h0);

        // Flush in IDLE
        flush = 1'b1;
        #1;
        checkVal("flushIdle.stillHit", 32'(stall), 32'd0);
        cycle();
        flush = 1'b0;
        #1;
        checkVal("flushIdle.noReq", 32'(mem_req), 32'd0);
        doRefill("postFlush", 32'h0);

        // Flush mid-refill of 0x100 (into line 0) after two acks
        pc = 32'h100;
        #1;
        checkVal("flushRef.miss", 32'(stall), 32'd1);
        cycle();
        cycle();
        cycle();
        checkVal("flushRef.addr2", mem_addr, 32'h108);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checkVal("flushRef.addr3", mem_addr, 32'h10C);
        checkVal("flushRef.req3", 32'(mem_req), 32'd1);
        cycle();
        checkVal("flushRef.reqDrop", 32'(mem_req), 32'd0);
        checkVal("flushRef.lineInvalid", 32'(stall), 32'd1);
        checkVal("flushRef.instrNop", instr, NOP);
        pc = 32'h0;
        #1;
        doRefill("afterKill", 32'h0);

        // Reset in the middle of a refill
        pc = 32'h100;
        #1;
        cycle();
        cycle();
        cycle();
        checkVal("rstRef.reqUp", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        checkVal("rstRef.reqAsync", 32'(mem_req), 32'd0);
        checkVal("rstRef.addrAsync", mem_addr, 32'h0);
        cycle();
        cycle();
        reset = 1'b1;
        pc = 32'h0;
        #1;
        checkVal("rstRef.validCleared", 32'(stall), 32'd1);
        doRefill("postRst", 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
